// File: rtl/types_pkg.sv
// Shared types for the I2C transaction scheduler: requester op, byte-engine
// command codes and the transaction state encoding.
package types_pkg;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } txn_state_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among active requests, searching from
// the priority pointer; the pointer moves one past the winner on advance.
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;
    int               pos;

    // Pick the first active request at or after the pointer, wrapping around.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            idx = PTR_W'(pos);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            gnt_o[win] = 1'b1;
            if (advance_i) begin
                ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : PTR_W'(int'(win) + 1);
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Arbitrates requesters onto a single I2C byte engine and sequences each
// transaction as START, address WRITE, data WRITE/READ bytes, STOP. Every
// command state has an issue phase (cmd_valid until cmd_ready) and a wait
// phase (until rsp_valid), so exactly one command is ever outstanding.
module i2c_txn_scheduler
    import types_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 5
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ-1:0][I2C_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                      req_op,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]       req_len,
    output logic [NUM_REQ-1:0]                      gnt,
    input  logic                                    wdata_valid,
    output logic                                    wdata_ready,
    input  logic [I2C_DATA_WIDTH-1:0]               wdata,
    output logic                                    rdata_valid,
    output logic [I2C_DATA_WIDTH-1:0]               rdata,
    output logic                                    rdata_last,
    output logic                                    done,
    output logic                                    done_nack,
    output logic                                    cmd_valid,
    input  logic                                    cmd_ready,
    output i2c_cmd_t                                cmd_code,
    output logic [I2C_DATA_WIDTH-1:0]               cmd_data,
    output logic                                    cmd_nack,
    input  logic                                    rsp_valid,
    input  logic [I2C_DATA_WIDTH-1:0]               rsp_data,
    input  logic                                    rsp_nack
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    txn_state_t                state_q, state_d;
    logic                      wait_q, wait_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
    i2c_op_t                   op_q, op_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      nack_q, nack_d;
    logic [I2C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rdata_valid_q, rdata_valid_d;
    logic                      rdata_last_q, rdata_last_d;

    logic [NUM_REQ-1:0]        arb_gnt;
    logic                      arb_advance;
    logic [I2C_ADDR_WIDTH-1:0] sel_addr;
    logic                      sel_op;
    logic [LEN_WIDTH-1:0]      sel_len;

    // Requests are only looked at in IDLE, so later req_valid changes are ignored.
    assign arb_advance = (state_q == ST_IDLE) && rst_ni && (|req_valid);

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_valid),
        .advance_i(arb_advance),
        .gnt_o    (arb_gnt)
    );

    // One-hot select of the winning requester's transaction fields.
    always_comb begin
        sel_addr = '0;
        sel_op   = 1'b0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = sel_addr | req_addr[i];
                sel_op   = sel_op | req_op[i];
                sel_len  = sel_len | req_len[i];
            end
        end
    end

    // Next-state, command issue and response handling.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        nack_d        = nack_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        rdata_last_d  = 1'b0;
        req_ready     = '0;
        cmd_valid     = 1'b0;
        cmd_code      = CMD_START;
        cmd_data      = '0;
        cmd_nack      = 1'b0;
        wdata_ready   = 1'b0;
        done          = 1'b0;
        done_nack     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_advance) begin
                    req_ready = arb_gnt;
                    gnt_d     = arb_gnt;
                    addr_d    = sel_addr;
                    op_d      = i2c_op_t'(sel_op);
                    cnt_d     = sel_len;
                    nack_d    = 1'b0;
                    wait_d    = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                cmd_valid = !wait_q;
                cmd_code  = CMD_START;
                if (wait_q && rsp_valid) begin
                    wait_d  = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cmd_valid = !wait_q;
                cmd_code  = CMD_WRITE;
                cmd_data  = {addr_q, op_q};
                if (wait_q && rsp_valid) begin
                    wait_d = 1'b0;
                    if (rsp_nack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (cnt_q == '0) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (op_q == OP_READ) begin
                    cmd_valid = !wait_q;
                    cmd_code  = CMD_READ;
                    cmd_nack  = (cnt_q == LEN_ONE);
                end else begin
                    // The write byte is consumed exactly when the engine takes it.
                    cmd_valid   = !wait_q && wdata_valid;
                    cmd_code    = CMD_WRITE;
                    cmd_data    = wdata;
                    wdata_ready = cmd_valid && cmd_ready;
                end
                if (wait_q && rsp_valid) begin
                    wait_d = 1'b0;
                    cnt_d  = cnt_q - LEN_ONE;
                    if (op_q == OP_READ) begin
                        rdata_valid_d = 1'b1;
                        rdata_d       = rsp_data;
                        rdata_last_d  = (cnt_q == LEN_ONE);
                    end
                    if (op_q == OP_WRITE && rsp_nack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (cnt_q == LEN_ONE) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                cmd_valid = !wait_q;
                cmd_code  = CMD_STOP;
                if (wait_q && rsp_valid) begin
                    wait_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                done_nack = nack_q;
                gnt_d     = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 1'b0;
                gnt_d   = '0;
            end
        endcase

        if (!wait_q && cmd_valid && cmd_ready) wait_d = 1'b1;
    end

    assign gnt         = gnt_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;

    // Transaction state registers; reset abandons any transaction without STOP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            wait_q        <= 1'b0;
            gnt_q         <= '0;
            addr_q        <= '0;
            op_q          <= OP_WRITE;
            cnt_q         <= '0;
            nack_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            gnt_q         <= gnt_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            nack_q        <= nack_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler: a table of transactions is played
// against a behavioural byte engine; the command stream, read data, write
// handshakes, grants and done/done_nack are compared against expectations.
module tb_i2c_txn_scheduler;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][6:0] req_addr;
    logic [1:0]      req_op;
    logic [1:0][4:0] req_len;
    logic [1:0]      gnt;
    logic            wdata_valid;
    logic            wdata_ready;
    logic [7:0]      wdata;
    logic            rdata_valid;
    logic [7:0]      rdata;
    logic            rdata_last;
    logic            done;
    logic            done_nack;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_code;
    logic [7:0]      cmd_data;
    logic            cmd_nack;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_nack;

    always #5 clk = ~clk;

    i2c_txn_scheduler dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .req_len    (req_len),
        .gnt        (gnt),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata      (wdata),
        .rdata_valid(rdata_valid),
        .rdata      (rdata),
        .rdata_last (rdata_last),
        .done       (done),
        .done_nack  (done_nack),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_data   (cmd_data),
        .cmd_nack   (cmd_nack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_nack   (rsp_nack)
    );

    // nack_at / abort_at index the engine command stream: 0 START, 1 address, 2.. data.
    typedef struct {
        logic [1:0] vmask;
        int         exp_win;
        logic       op;
        logic [6:0] addr;
        logic [4:0] len;
        logic [7:0] d [4];
        int         nack_at;
        int         stall;
        int         abort_at;
        bit         pre_reset;
        logic       exp_nack;
        int         exp_ncmd;
    } vec_t;

    vec_t vecs [10];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [1:0] vm, input int win, input logic op,
                                input logic [6:0] a, input logic [4:0] len,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3,
                                input int nack_at, input int stall, input int abort_at,
                                input bit pre_reset, input logic en, input int encmd);
        vec_t v;
        v.vmask = vm; v.exp_win = win; v.op = op; v.addr = a; v.len = len;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.nack_at = nack_at; v.stall = stall; v.abort_at = abort_at;
        v.pre_reset = pre_reset; v.exp_nack = en; v.exp_ncmd = encmd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_nack    = 1'b0;
        wdata_valid = 1'b0;
        wdata       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input int vi);
        int ecode [16]; int edat [16]; int enk [16]; int en; int ewr; int erd;
        int rcode [16]; int rdat [16]; int rnk [16]; int rn;
        int win, acc, stall_cnt, widx, ridx, wrdy, gnt_err, stab_err, rd_err, pend_idx;
        bit granted, dropped, saw_done, aborted, cur_act, pending;
        logic [1:0] cc; logic [7:0] cd; logic cn; logic dn;
        logic [7:0] pend_data; logic pend_nack;

        en = 0; ewr = 0; erd = 0; rn = 0;
        win = -1; acc = 0; stall_cnt = 0; widx = 0; ridx = 0; wrdy = 0;
        gnt_err = 0; stab_err = 0; rd_err = 0; pend_idx = -1;
        granted = 0; dropped = 0; saw_done = 0; aborted = 0; cur_act = 0; pending = 0;
        cc = '0; cd = '0; cn = 1'b0; dn = 1'b0; pend_data = '0; pend_nack = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ecode[k] = 0; edat[k] = 0; enk[k] = 0; rcode[k] = -1; rdat[k] = -1; rnk[k] = -1;
        end

        // Expected engine command stream.
        ecode[en] = 0; edat[en] = 0; enk[en] = 0; en++;
        ecode[en] = 1; edat[en] = int'({v.addr, v.op}); enk[en] = 0; en++;
        if (v.nack_at != 1) begin
            for (int k = 0; k < int'(v.len); k++) begin
                if (v.op) begin
                    ecode[en] = 2; edat[en] = 0; enk[en] = (k == int'(v.len) - 1) ? 1 : 0; en++;
                    erd++;
                end else begin
                    ecode[en] = 1; edat[en] = int'(v.d[k % 4]); enk[en] = 0; en++;
                    ewr++;
                    if (v.nack_at == 2 + k) break;
                end
            end
        end
        ecode[en] = 3; edat[en] = 0; enk[en] = 0; en++;

        req_addr[0] = v.addr; req_addr[1] = v.addr;
        req_op      = {v.op, v.op};
        req_len[0]  = v.len;  req_len[1]  = v.len;
        req_valid   = v.vmask;

        for (int cyc = 0; cyc < 300 && !saw_done && !aborted; cyc++) begin
            if (v.abort_at >= 0 && pending && pend_idx == v.abort_at) begin
                aborted = 1;
                cmd_ready = 1'b0; rsp_valid = 1'b0; wdata_valid = 1'b0;
            end else begin
                rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = '0;
                if (pending) begin
                    rsp_valid = 1'b1; rsp_nack = pend_nack; rsp_data = pend_data;
                    pending = 0;
                end
                wdata_valid = granted && !v.op && (widx < int'(v.len));
                wdata       = v.d[widx % 4];
                cmd_ready   = (stall_cnt >= v.stall);
                #1;
                if (!granted) begin
                    if (req_ready != 2'b00) begin
                        granted = 1;
                        win = req_ready[1] ? 1 : 0;
                        check($sformatf("v%0d_grant", vi), req_ready, 2'b01 << v.exp_win);
                    end
                end else begin
                    if (gnt !== (2'b01 << win)) gnt_err++;
                    if (req_ready !== 2'b00) gnt_err++;
                end
                if (cur_act && !cmd_valid) begin
                    stab_err++;
                    cur_act = 0;
                end
                if (cmd_valid) begin
                    if (!cur_act) begin
                        cc = cmd_code; cd = cmd_data; cn = cmd_nack; cur_act = 1;
                    end else if (cmd_code !== cc || cmd_data !== cd || cmd_nack !== cn) begin
                        stab_err++;
                    end
                    if (cmd_ready) begin
                        if (rn < 16) begin
                            rcode[rn] = int'(cmd_code); rdat[rn] = int'(cmd_data); rnk[rn] = int'(cmd_nack);
                        end
                        rn++;
                        pend_idx  = acc;
                        acc++;
                        pending   = 1;
                        pend_nack = (pend_idx == v.nack_at);
                        pend_data = (cmd_code == 2'd2 && pend_idx >= 2) ? v.d[(pend_idx - 2) % 4] : 8'h00;
                        cur_act   = 0;
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
                if (wdata_ready) begin
                    wrdy++;
                    if (!(cmd_valid && cmd_ready)) stab_err++;
                    widx++;
                end
                if (rdata_valid) begin
                    if (ridx >= 4 || rdata !== v.d[ridx % 4] ||
                        rdata_last !== (ridx == int'(v.len) - 1)) rd_err++;
                    ridx++;
                end
                if (done) begin
                    saw_done = 1;
                    dn = done_nack;
                end
                @(posedge clk);
                #1;
                if (granted && !dropped) begin
                    req_valid = v.vmask & ~(2'b01 << win);
                    dropped = 1;
                end
            end
        end

        if (!aborted) begin
            check($sformatf("v%0d_done_seen", vi), 32'(saw_done), 1);
            check($sformatf("v%0d_ncmd", vi), rn, v.exp_ncmd);
            for (int k = 0; k < en; k++) begin
                check($sformatf("v%0d_cmd%0d_code", vi, k), rcode[k], ecode[k]);
                check($sformatf("v%0d_cmd%0d_data", vi, k), rdat[k], edat[k]);
                check($sformatf("v%0d_cmd%0d_nack", vi, k), rnk[k], enk[k]);
            end
            if (vi == 0) check("v0_addr_byte", rdat[1], 32'h44);
            check($sformatf("v%0d_wdata_ready_cnt", vi), wrdy, ewr);
            check($sformatf("v%0d_rdata_cnt", vi), ridx, erd);
            check($sformatf("v%0d_rdata_err", vi), rd_err, 0);
            check($sformatf("v%0d_gnt_err", vi), gnt_err, 0);
            check($sformatf("v%0d_cmd_stable_err", vi), stab_err, 0);
            check($sformatf("v%0d_done_nack", vi), 32'(dn), 32'(v.exp_nack));
            check($sformatf("v%0d_done_pulse", vi), 32'(done), 0);
            check($sformatf("v%0d_gnt_release", vi), gnt, 0);
        end
    endtask

    initial begin
        idle_inputs();
        req_addr = '0; req_op = '0; req_len = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_gnt", gnt, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata_valid", 32'(rdata_valid), 0);
        check("rst_wdata_ready", 32'(wdata_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //            vmask  win op    addr   len   d0     d1     d2     d3    nack stl abort rst nack ncmd
        vecs[0] = mk(2'b01, 0, 1'b0, 7'h22, 5'd2, 8'hA5, 8'h5A, 8'h00, 8'h00, -1, 0, -1, 0, 1'b0, 5);
        vecs[1] = mk(2'b10, 1, 1'b1, 7'h10, 5'd3, 8'h01, 8'h02, 8'h03, 8'h00, -1, 0, -1, 0, 1'b0, 6);
        vecs[2] = mk(2'b01, 0, 1'b0, 7'h33, 5'd4, 8'h11, 8'h22, 8'h33, 8'h44,  1, 0, -1, 0, 1'b1, 3);
        vecs[3] = mk(2'b11, 0, 1'b0, 7'h05, 5'd1, 8'h3C, 8'h00, 8'h00, 8'h00, -1, 0, -1, 1, 1'b0, 4);
        vecs[4] = mk(2'b11, 1, 1'b1, 7'h7F, 5'd1, 8'hE7, 8'h00, 8'h00, 8'h00, -1, 0, -1, 0, 1'b0, 4);
        vecs[5] = mk(2'b11, 0, 1'b0, 7'h01, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, -1, 0, -1, 0, 1'b0, 3);
        vecs[6] = mk(2'b11, 1, 1'b0, 7'h55, 5'd3, 8'h10, 8'h20, 8'h30, 8'h00,  2, 0, -1, 0, 1'b1, 4);
        vecs[7] = mk(2'b01, 0, 1'b0, 7'h2A, 5'd1, 8'hC3, 8'h00, 8'h00, 8'h00, -1, 5, -1, 0, 1'b0, 4);
        vecs[8] = mk(2'b01, 0, 1'b1, 7'h10, 5'd3, 8'h0A, 8'h0B, 8'h0C, 8'h00, -1, 0,  2, 0, 1'b0, 0);
        vecs[9] = mk(2'b11, 0, 1'b1, 7'h08, 5'd2, 8'h9A, 8'hBC, 8'h00, 8'h00, -1, 0, -1, 0, 1'b0, 5);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].pre_reset) do_reset();
            run_txn(vecs[i], i);
            if (vecs[i].abort_at >= 0) begin
                // Reset while the engine owes a DATA response.
                check("abort_gnt_held", gnt, 2'b01 << vecs[i].exp_win);
                rst_n = 1'b0;
                #1;
                check("abort_cmd_valid", 32'(cmd_valid), 0);
                check("abort_gnt", gnt, 0);
                check("abort_done", 32'(done), 0);
                idle_inputs();
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
